// File: rtl/bnn_pkg.sv
// Shared types, state encodings and width helpers for the sequential BNN classifier.
package bnn_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_HID  = 2'd1;
  localparam state_t ST_OUT  = 2'd2;
  localparam state_t ST_DONE = 2'd3;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Signed neuron accumulator width: B-bit magnitudes summed over n features, plus sign.
  function automatic int sum_w(input int n, input int b);
    return b + clog2(n) + 1;
  endfunction

  function automatic int pc_w(input int m);
    return clog2(m + 1);
  endfunction

  // Counter width that stays at least one bit wide when the count is 1.
  function automatic int cnt_w(input int v);
    return (v <= 1) ? 1 : clog2(v);
  endfunction

endpackage

// File: rtl/bnn_seq_classifier_if.sv
// Feature-in / class-out streaming interface of the sequential BNN classifier.
interface bnn_seq_classifier_if
  import bnn_pkg::*;
#(
  parameter int N = 11,
  parameter int B = 4,
  parameter int M = 40,
  parameter int C = 6
);

  logic                  in_valid;
  logic                  in_ready;
  logic [N*B-1:0]        inp;
  logic                  out_valid;
  logic                  out_ready;
  logic [clog2(C)-1:0]   klass;
  logic [pc_w(M)-1:0]    score;

  modport master (
    output in_valid, inp, out_ready,
    input  in_ready, out_valid, klass, score
  );

  modport slave (
    input  in_valid, inp, out_ready,
    output in_ready, out_valid, klass, score
  );

endinterface

// File: rtl/bnn_neuron_sum.sv
// One binarized hidden neuron: signed +/- sum of the features, reduced to its sign.
module bnn_neuron_sum
  import bnn_pkg::*;
#(
  parameter int N = 11,
  parameter int B = 4
) (
  input  logic [N*B-1:0] x_i,
  input  logic [N-1:0]   w_row_i,
  output logic           pos_o
);

  localparam int SW = sum_w(N, B);

  logic signed [SW-1:0] acc;
  logic signed [SW-1:0] term;

  // NOTE: every variable is given a default first so no latch can be inferred.
  always_comb begin
    acc  = '0;
    term = '0;
    for (int j = 0; j < N; j++) begin
      term = SW'(x_i[j*B +: B]);
      acc  = w_row_i[j] ? acc + term : acc - term;
    end
  end

  // Strictly positive: sign clear and not zero.
  assign pos_o = !acc[SW-1] && (acc != '0);

endmodule

// File: rtl/bnn_seq_classifier.sv
// Time-multiplexed binarized-NN classifier: P hidden neurons per cycle, then one class per cycle.
module bnn_seq_classifier
  import bnn_pkg::*;
#(
  parameter int               N  = 11,
  parameter int               B  = 4,
  parameter int               M  = 40,
  parameter int               C  = 6,
  parameter int               P  = 8,
  parameter logic [M*N-1:0]   W1 = {M*N{1'b1}},
  parameter logic [C*M-1:0]   W2 = '0
) (
  input logic                 clk,
  input logic                 rst_n,
  bnn_seq_classifier_if.slave bus
);

  localparam int G  = (M + P - 1) / P;
  localparam int HP = G * P;
  localparam int GW = cnt_w(G);
  localparam int KW = clog2(C);
  localparam int PW = pc_w(M);

  // Weight rows padded to whole groups so the last group's spare lanes read zeros.
  localparam logic [HP*N-1:0] W1_PAD = (HP*N)'(W1);

  state_t          state_q, state_d;
  logic [N*B-1:0]  x_q;
  logic [GW-1:0]   g_q;
  logic [KW-1:0]   k_q;
  logic [M-1:0]    h_q, h_d;
  logic [PW-1:0]   best_q;
  logic [KW-1:0]   bidx_q;

  logic            accept;
  logic [HP*N-1:0] w_shift;
  logic [P-1:0]    pos;
  logic [HP-1:0]   h_pad;
  logic [C*M-1:0]  w2_shift;
  logic [M-1:0]    match;
  logic [PW-1:0]   pc;
  logic            better;

  assign accept = bus.in_valid & bus.in_ready;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (accept)                 state_d = ST_HID;
      ST_HID:  if (g_q == GW'(G - 1))      state_d = ST_OUT;
      ST_OUT:  if (k_q == KW'(C - 1))      state_d = ST_DONE;
      ST_DONE: if (accept)                 state_d = ST_HID;
               else if (bus.out_ready)     state_d = ST_IDLE;
      default:                             state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.out_valid = (state_q == ST_DONE);
    bus.in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && bus.out_ready);
  end

  assign bus.klass = bidx_q;
  assign bus.score = best_q;

  // Hidden layer: the group counter selects which P weight rows feed the lanes.
  always_comb w_shift = W1_PAD >> (int'(g_q) * P * N);

  for (genvar p = 0; p < P; p++) begin : g_lane
    bnn_neuron_sum #(.N(N), .B(B)) u_sum (
      .x_i     (x_q),
      .w_row_i (w_shift[p*N +: N]),
      .pos_o   (pos[p])
    );
  end

  // Lanes beyond M land in the padding bits and are dropped by the truncation.
  always_comb begin
    h_pad = (HP'(h_q) & ~(HP'({P{1'b1}}) << (int'(g_q) * P)))
          | (HP'(pos) << (int'(g_q) * P));
    h_d   = h_pad[M-1:0];
  end

  // Output layer: XNOR popcount for class k, strict compare keeps the lowest index on ties.
  always_comb begin
    w2_shift = W2 >> (int'(k_q) * M);
    match    = ~(h_q ^ w2_shift[M-1:0]);
    pc       = '0;
    for (int i = 0; i < M; i++) pc = pc + PW'(match[i]);
    better   = (k_q == '0) || (pc > best_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q    <= '0;
      g_q    <= '0;
      k_q    <= '0;
      h_q    <= '0;
      best_q <= '0;
      bidx_q <= '0;
    end else begin
      if (accept) begin
        x_q <= bus.inp;
        g_q <= '0;
        k_q <= '0;
      end
      if (state_q == ST_HID) begin
        h_q <= h_d;
        g_q <= g_q + 1'b1;
      end
      if (state_q == ST_OUT) begin
        k_q <= k_q + 1'b1;
        if (better) begin
          best_q <= pc;
          bidx_q <= k_q;
        end
      end
    end
  end

endmodule

// File: tb/tb_bnn_seq_classifier.sv
// Self-checking bench: small hand-checkable configs plus default-size configs (P=8, P=7)
// compared against an arithmetic reference model.
module tb_bnn_seq_classifier;
  import bnn_pkg::*;

  function automatic logic [511:0] prbs(input int unsigned seed);
    logic [31:0]  s;
    logic [511:0] r;
    s = seed;
    r = '0;
    for (int i = 0; i < 512; i++) begin
      s ^= s << 13;
      s ^= s >> 17;
      s ^= s << 5;
      r[i] = s[0];
    end
    return r;
  endfunction

  localparam logic [7:0]   W1_S   = 8'hFF;
  localparam logic [7:0]   W2_A   = 8'hF0;
  localparam logic [7:0]   W2_B   = 8'h33;
  localparam logic [439:0] W1_BIG = 440'(prbs(32'h1234_5678));
  localparam logic [239:0] W2_BIG = 240'(prbs(32'h0BAD_CAFE));

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  logic        s_in_valid = 1'b0, s_out_ready = 1'b0;
  logic [7:0]  s_inp = '0;
  logic        b_in_valid = 1'b0, b_out_ready = 1'b0;
  logic [43:0] b_inp = '0;

  bnn_seq_classifier_if #(.N(2),  .B(4), .M(4),  .C(2)) if_a ();
  bnn_seq_classifier_if #(.N(2),  .B(4), .M(4),  .C(2)) if_b ();
  bnn_seq_classifier_if #(.N(11), .B(4), .M(40), .C(6)) if_c ();
  bnn_seq_classifier_if #(.N(11), .B(4), .M(40), .C(6)) if_d ();

  assign if_a.in_valid = s_in_valid;  assign if_a.inp = s_inp;  assign if_a.out_ready = s_out_ready;
  assign if_b.in_valid = s_in_valid;  assign if_b.inp = s_inp;  assign if_b.out_ready = s_out_ready;
  assign if_c.in_valid = b_in_valid;  assign if_c.inp = b_inp;  assign if_c.out_ready = b_out_ready;
  assign if_d.in_valid = b_in_valid;  assign if_d.inp = b_inp;  assign if_d.out_ready = b_out_ready;

  bnn_seq_classifier #(.N(2), .B(4), .M(4), .C(2), .P(1), .W1(W1_S), .W2(W2_A))
    u_a (.clk(clk), .rst_n(rst_n), .bus(if_a.slave));
  bnn_seq_classifier #(.N(2), .B(4), .M(4), .C(2), .P(1), .W1(W1_S), .W2(W2_B))
    u_b (.clk(clk), .rst_n(rst_n), .bus(if_b.slave));
  bnn_seq_classifier #(.N(11), .B(4), .M(40), .C(6), .P(8), .W1(W1_BIG), .W2(W2_BIG))
    u_c (.clk(clk), .rst_n(rst_n), .bus(if_c.slave));
  bnn_seq_classifier #(.N(11), .B(4), .M(40), .C(6), .P(7), .W1(W1_BIG), .W2(W2_BIG))
    u_d (.clk(clk), .rst_n(rst_n), .bus(if_d.slave));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: full hidden layer with integer sums, then best XNOR-match count, first index wins.
  function automatic void ref_model(input int n, input int b, input int m, input int c,
                                    input logic [511:0] w1, input logic [511:0] w2,
                                    input logic [63:0] x, output int kl, output int sc);
    int h[64];
    int s, xj, pc;
    for (int i = 0; i < m; i++) begin
      s = 0;
      for (int j = 0; j < n; j++) begin
        xj = int'((x >> (j * b)) & ((64'd1 << b) - 1));
        s  = w1[i*n + j] ? s + xj : s - xj;
      end
      h[i] = (s > 0) ? 1 : 0;
    end
    kl = 0;
    sc = -1;
    for (int k = 0; k < c; k++) begin
      pc = 0;
      for (int i = 0; i < m; i++) if (h[i] == int'(w2[k*m + i])) pc++;
      if (pc > sc) begin
        sc = pc;
        kl = k;
      end
    end
  endfunction

  task automatic small_run(input logic [7:0] x, input int stall);
    int ka, sa, kb, sb, n;
    ref_model(2, 4, 4, 2, 512'(W1_S), 512'(W2_A), 64'(x), ka, sa);
    ref_model(2, 4, 4, 2, 512'(W1_S), 512'(W2_B), 64'(x), kb, sb);
    @(negedge clk);
    s_in_valid = 1'b1; s_inp = x; s_out_ready = 1'b0;
    #1 check("s_in_ready", if_a.in_ready & if_b.in_ready, 1);
    @(negedge clk);
    s_in_valid = 1'b0; s_inp = 8'($urandom);
    n = 1;
    while (!if_a.out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("s_latency", n, 7);
    check("s_valid_b", if_b.out_valid, 1);
    check("s_klass_a", if_a.klass, ka);
    check("s_score_a", if_a.score, sa);
    check("s_klass_b", if_b.klass, kb);
    check("s_score_b", if_b.score, sb);
    repeat (stall) begin
      @(negedge clk);
      check("s_hold_valid", if_a.out_valid, 1);
      check("s_hold_klass", if_a.klass, ka);
      check("s_hold_score", if_a.score, sa);
    end
    s_out_ready = 1'b1;
    @(negedge clk);
    check("s_drop_valid", if_a.out_valid, 0);
    s_out_ready = 1'b0;
  endtask

  task automatic big_run(input logic [43:0] x);
    int ek, es, lat_c, lat_d;
    logic [2:0] kc, kd;
    logic [5:0] sc, sd;
    ref_model(11, 4, 40, 6, 512'(W1_BIG), 512'(W2_BIG), 64'(x), ek, es);
    kc = '0; kd = '0; sc = '0; sd = '0;
    @(negedge clk);
    b_in_valid = 1'b1; b_inp = x; b_out_ready = 1'b1;
    #1 check("b_in_ready", {if_c.in_ready, if_d.in_ready}, 2'b11);
    @(negedge clk);
    b_in_valid = 1'b0; b_inp = 44'({$urandom, $urandom});
    lat_c = 0; lat_d = 0;
    for (int lat = 1; lat <= 40 && (lat_c == 0 || lat_d == 0); lat++) begin
      if (lat_c == 0 && if_c.out_valid) begin lat_c = lat; kc = if_c.klass; sc = if_c.score; end
      if (lat_d == 0 && if_d.out_valid) begin lat_d = lat; kd = if_d.klass; sd = if_d.score; end
      @(negedge clk);
    end
    check("b_latency_p8", lat_c, 12);
    check("b_latency_p7", lat_d, 13);
    check("b_klass_p8", kc, ek);
    check("b_score_p8", sc, es);
    check("b_klass_p7", kd, ek);
    check("b_score_p7", sd, es);
    b_out_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, ka, sa;

    repeat (3) @(negedge clk);
    check("rst_valid_a", if_a.out_valid, 0);
    check("rst_klass_a", if_a.klass, 0);
    check("rst_score_a", if_a.score, 0);
    check("rst_ready_a", if_a.in_ready, 1);
    check("rst_valid_c", if_c.out_valid, 0);
    check("rst_score_c", if_c.score, 0);
    rst_n = 1'b1;

    small_run(8'h00, 0);
    small_run(8'h31, 3);
    small_run(8'h11, 1);
    for (int i = 0; i < 6; i++) small_run(8'($urandom), int'($urandom_range(0, 2)));

    // Back-to-back streaming with out_ready held high; busy-time in_valid must be ignored.
    @(negedge clk);
    s_out_ready = 1'b1; s_in_valid = 1'b1; s_inp = 8'h31;
    #1 check("t4_accept1", if_a.in_ready, 1);
    @(negedge clk);
    s_inp = 8'h00;
    check("t4_busy_ready", if_a.in_ready, 0);
    n = 1;
    while (!if_a.out_valid && n < 40) begin @(negedge clk); n++; end
    ref_model(2, 4, 4, 2, 512'(W1_S), 512'(W2_A), 64'h31, ka, sa);
    check("t4_latency1", n, 7);
    check("t4_klass1", if_a.klass, ka);
    check("t4_score1", if_a.score, sa);
    #1 check("t4_done_ready", if_a.in_ready, 1);
    @(negedge clk);
    s_in_valid = 1'b0;
    n = 1;
    while (!if_a.out_valid && n < 40) begin @(negedge clk); n++; end
    ref_model(2, 4, 4, 2, 512'(W1_S), 512'(W2_A), 64'h00, ka, sa);
    check("t4_latency2", n, 7);
    check("t4_klass2", if_a.klass, ka);
    check("t4_score2", if_a.score, sa);
    @(negedge clk);
    check("t4_drop_valid", if_a.out_valid, 0);
    s_out_ready = 1'b0;

    big_run(44'h46012229a22);
    big_run(44'h58022538633);
    big_run(44'h92912439523);
    for (int i = 0; i < 10; i++) big_run(44'({$urandom, $urandom}));

    // Reset in the middle of the output layer.
    @(negedge clk);
    s_in_valid = 1'b1; s_inp = 8'h31;
    @(negedge clk);
    s_in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t6_valid", if_a.out_valid, 0);
    check("t6_ready", if_a.in_ready, 1);
    check("t6_klass", if_a.klass, 0);
    check("t6_score", if_a.score, 0);
    @(negedge clk);
    rst_n = 1'b1;
    small_run(8'h31, 0);
    small_run(8'h00, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
